// File: rtl/ahb_crc_slave.sv
// AHB-Lite slave that computes an MSB-first CRC-32 over the bytes written to DATA.
// Define CRC_SUBWORD_EN to accept byte/halfword DATA writes; without it they get an ERROR response.
module ahb_crc_slave #(
  parameter logic [31:0] POLY     = 32'h04C11DB7,
  parameter logic [31:0] SEED_RST = 32'hFFFFFFFF
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);
  // state   | meaning
  // ST_IDLE | no data phase in progress
  // ST_XFER | legal transfer in its data phase
  // ST_ERR1 | ERROR cycle 1 (HREADYOUT low), address phases ignored
  // ST_ERR2 | ERROR cycle 2 (HREADYOUT high), next address phase may be taken
  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_ERR1, ST_ERR2} state_t;

  localparam logic [2:0] R_DATA  = 3'd0;
  localparam logic [2:0] R_CRC   = 3'd1;
  localparam logic [2:0] R_SEED  = 3'd2;
  localparam logic [2:0] R_CTRL  = 3'd3;
  localparam logic [2:0] R_COUNT = 3'd4;

  state_t      state, state_nxt;
  logic [31:0] crc, seed, crc_data;
  logic [15:0] count, count_nxt;
  logic [16:0] count_sum;
  logic [2:0]  n_bytes;
  logic [4:0]  dp_addr;
  logic [1:0]  dp_size;
  logic        dp_write;
  logic        accept, addr_err;
  logic [2:0]  a_reg;
  logic        unused_bits;
`ifdef CRC_SUBWORD_EN
  logic [15:0] hw;
`endif

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--)
      r = (r[31] ^ d[i]) ? ({r[30:0], 1'b0} ^ POLY) : {r[30:0], 1'b0};
    return r;
  endfunction

  always_comb begin
    a_reg    = HADDR[4:2];
    addr_err = 1'b0;
    if (HSIZE > 3'd2 || a_reg > R_COUNT)                   addr_err = 1'b1;
    if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)              addr_err = 1'b1;
    if (HSIZE == 3'd1 && HADDR[0])                         addr_err = 1'b1;
    if (HSIZE != 3'd2 && a_reg != R_DATA)                  addr_err = 1'b1;
    if (HWRITE && (a_reg == R_CRC || a_reg == R_COUNT))    addr_err = 1'b1;
`ifndef CRC_SUBWORD_EN
    if (HWRITE && HSIZE != 3'd2)                           addr_err = 1'b1;
`endif
  end

  // ERROR cycle 1 drives HREADYOUT low, so anything on the bus then is not a real address phase
  assign accept = HSEL && HREADY && HTRANS[1] && (state != ST_ERR1);

  always_comb begin
    state_nxt = ST_IDLE;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    if (state == ST_ERR1)
      state_nxt = ST_ERR2;
    else if (accept)
      state_nxt = addr_err ? ST_ERR1 : ST_XFER;
    if (state == ST_ERR1) HREADYOUT = 1'b0;
    if (state == ST_ERR1 || state == ST_ERR2) HRESP = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_addr  <= 5'd0;
      dp_write <= 1'b0;
      dp_size  <= 2'd0;
    end else if (accept && !addr_err) begin
      dp_addr  <= HADDR[4:0];
      dp_write <= HWRITE;
      dp_size  <= HSIZE[1:0];
    end
  end

  always_comb begin
    crc_data = crc_byte(crc_byte(crc_byte(crc_byte(crc, HWDATA[31:24]), HWDATA[23:16]),
                                 HWDATA[15:8]), HWDATA[7:0]);
    n_bytes  = 3'd4;
`ifdef CRC_SUBWORD_EN
    hw = dp_addr[1] ? HWDATA[31:16] : HWDATA[15:0];
    if (dp_size == 2'd1) begin
      crc_data = crc_byte(crc_byte(crc, hw[15:8]), hw[7:0]);
      n_bytes  = 3'd2;
    end else if (dp_size == 2'd0) begin
      crc_data = crc_byte(crc, HWDATA[{dp_addr[1:0], 3'b000} +: 8]);
      n_bytes  = 3'd1;
    end
`endif
    count_sum = {1'b0, count} + {14'd0, n_bytes};
    count_nxt = count_sum[16] ? 16'hFFFF : count_sum[15:0];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      crc   <= SEED_RST;
      seed  <= SEED_RST;
      count <= 16'd0;
    end else if (state == ST_XFER && dp_write) begin
      case (dp_addr[4:2])
        R_DATA: begin
          crc   <= crc_data;
          count <= count_nxt;
        end
        R_SEED: seed <= HWDATA;
        R_CTRL: if (HWDATA[0]) begin
          crc   <= seed;
          count <= 16'd0;
        end
        default: ;
      endcase
    end
  end

  // Registers only change at the end of a data phase, so a combinational mux gives start-of-phase values
  always_comb begin
    HRDATA = 32'h0;
    if (state == ST_XFER && !dp_write) begin
      case (dp_addr[4:2])
        R_CRC:   HRDATA = crc;
        R_SEED:  HRDATA = seed;
        R_COUNT: HRDATA = {16'h0, count};
        default: HRDATA = 32'h0;
      endcase
    end
  end

  assign unused_bits = ^{HADDR[31:5], HTRANS[0], dp_size, dp_addr[1:0]};

endmodule

// File: tb/tb_ahb_crc_slave.sv
// Directed AHB transfers against ahb_crc_slave, checked every cycle against a byte-level CRC model,
// plus literal expectations on selected reads.
module tb_ahb_crc_slave;
  localparam logic [31:0] POLY     = 32'h04C11DB7;
  localparam logic [31:0] SEED_RST = 32'hFFFFFFFF;
`ifdef CRC_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = 32'h0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd0;
  logic [31:0] HWDATA = 32'h0;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        hready_ovr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  assign HREADY = HREADYOUT | hready_ovr;
  always #5 HCLK = ~HCLK;

  ahb_crc_slave #(.POLY(POLY), .SEED_RST(SEED_RST)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_crc, m_seed;
  int          m_count;
  bit          pd_valid, pd_write, pd_err;
  int          pd_stage;
  logic [4:0]  pd_addr;
  logic [2:0]  pd_size;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {b, 24'h0};
    repeat (8) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  function automatic bit model_legal(input logic wr, input logic [4:0] a, input logic [2:0] sz);
    int ri;
    ri = int'(a) / 4;
    if (sz > 3'd2) return 1'b0;
    if (ri > 4) return 1'b0;
    if ((int'(a) % (1 << int'(sz))) != 0) return 1'b0;
    if (ri != 0) return (sz == 3'd2) && !(wr && (ri == 1 || ri == 4));
    if (wr && sz != 3'd2) return SUBWORD;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (int'(a) / 4)
      1:       return m_crc;
      2:       return m_seed;
      4:       return 32'(m_count);
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_write(input logic [4:0] a, input logic [2:0] sz, input logic [31:0] w);
    logic [7:0]  bl [4];
    logic [15:0] h;
    int          n;
    case (int'(a) / 4)
      0: begin
        if (sz == 3'd2) begin
          n = 4; bl[0] = w[31:24]; bl[1] = w[23:16]; bl[2] = w[15:8]; bl[3] = w[7:0];
        end else if (sz == 3'd1) begin
          n = 2; h = a[1] ? w[31:16] : w[15:0]; bl[0] = h[15:8]; bl[1] = h[7:0];
        end else begin
          n = 1; bl[0] = 8'(w >> (8 * int'(a[1:0])));
        end
        for (int i = 0; i < n; i++) m_crc = crc_step(m_crc, bl[i]);
        m_count = (m_count + n > 65535) ? 65535 : m_count + n;
      end
      2: m_seed = w;
      3: if (w[0]) begin m_crc = m_seed; m_count = 0; end
      default: ;
    endcase
  endfunction

  function automatic void model_reset();
    m_crc = SEED_RST; m_seed = SEED_RST; m_count = 0;
    pd_valid = 1'b0; pd_write = 1'b0; pd_err = 1'b0; pd_stage = 0;
    pd_addr = 5'd0; pd_size = 3'd0;
  endfunction

  function automatic void model_advance();
    if (pd_valid && !pd_err && pd_write) model_write(pd_addr, pd_size, HWDATA);
    if (pd_valid && pd_err && pd_stage == 1) begin
      pd_stage = 2;
    end else if (HSEL && HREADY && HTRANS[1]) begin
      pd_valid = 1'b1; pd_write = HWRITE; pd_addr = HADDR[4:0]; pd_size = HSIZE;
      pd_err = !model_legal(HWRITE, HADDR[4:0], HSIZE); pd_stage = 1;
    end else begin
      pd_valid = 1'b0; pd_err = 1'b0; pd_stage = 0;
    end
  endfunction

  // Inputs are stable from posedge+1 to the next posedge, so the model steps on the falling edge
  always @(negedge HCLK) begin
    if (!HRESETn) model_reset();
    chk("model_hreadyout", {31'h0, HREADYOUT}, {31'h0, !(pd_valid && pd_err && pd_stage == 1)});
    chk("model_hresp", {31'h0, HRESP}, {31'h0, pd_valid && pd_err});
    chk("model_hrdata", HRDATA, (pd_valid && !pd_err && !pd_write) ? model_read(pd_addr) : 32'h0);
    if (HRESETn) model_advance();
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic        sel;
    logic [1:0]  tr;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic        c;
    logic [31:0] e;
    logic        ee;
  } txn_t;
  txn_t q[$];

  function automatic void push(input logic sel, input logic [1:0] tr, input logic wr,
                               input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                               input logic c, input logic [31:0] e, input logic ee);
    txn_t t;
    t.sel = sel; t.tr = tr; t.wr = wr; t.addr = a; t.sz = sz; t.wd = wd; t.c = c; t.e = e; t.ee = ee;
    q.push_back(t);
  endfunction

  function automatic void wr_q(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    push(1'b1, 2'b10, 1'b1, a, sz, wd, 1'b0, 32'h0, 1'b0);
  endfunction
  function automatic void wr_seq(input logic [31:0] a, input logic [31:0] wd);
    push(1'b1, 2'b11, 1'b1, a, 3'd2, wd, 1'b0, 32'h0, 1'b0);
  endfunction
  function automatic void wr_err(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    push(1'b1, 2'b10, 1'b1, a, sz, wd, 1'b1, 32'h0, 1'b1);
  endfunction
  function automatic void rd_q(input logic [31:0] a);
    push(1'b1, 2'b10, 1'b0, a, 3'd2, 32'h0, 1'b0, 32'h0, 1'b0);
  endfunction
  function automatic void rd_lit(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] e);
    push(1'b1, 2'b10, 1'b0, a, sz, 32'h0, 1'b1, e, 1'b0);
  endfunction
  function automatic void rd_err(input logic [31:0] a, input logic [2:0] sz);
    push(1'b1, 2'b10, 1'b0, a, sz, 32'h0, 1'b1, 32'h0, 1'b1);
  endfunction
  function automatic void no_dp(input logic sel, input logic [1:0] tr);
    push(sel, tr, 1'b1, 32'h0, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
  endfunction

  task automatic bus(input logic s, input logic [1:0] t, input logic w, input logic [31:0] a,
                     input logic [2:0] z);
    HSEL = s; HTRANS = t; HWRITE = w; HADDR = a; HSIZE = z;
  endtask

  task automatic tick();
    @(posedge HCLK); #1;
  endtask

  // Pipelined master: address phase of the next transfer overlaps the data phase of the current one
  task automatic run();
    int  ai, di, guard, n, limit;
    bit  rdy;
    ai = 0; di = -1; guard = 0; n = q.size(); limit = 4 * n + 20;
    while ((ai < n || di >= 0) && guard < limit) begin
      guard++;
      if (ai < n) bus(q[ai].sel, q[ai].tr, q[ai].wr, q[ai].addr, q[ai].sz);
      else        bus(1'b0, 2'b00, 1'b0, 32'h0, 3'd0);
      HWDATA = (di >= 0) ? q[di].wd : 32'h0;
      @(negedge HCLK);
      rdy = HREADY;
      if (di >= 0 && q[di].c) begin
        if (rdy) begin
          chk($sformatf("lit_hrdata@%h", q[di].addr), HRDATA, q[di].e);
          chk($sformatf("lit_hresp@%h", q[di].addr), {31'h0, HRESP}, {31'h0, q[di].ee});
        end else begin
          chk($sformatf("lit_err1_hresp@%h", q[di].addr), {31'h0, HRESP}, 32'h1);
        end
      end
      tick();
      if (rdy) begin
        di = -1;
        if (ai < n) begin
          if (q[ai].sel && q[ai].tr[1]) di = ai;
          ai++;
        end
      end
    end
    chk("run_completed", {31'h0, guard >= limit}, 32'h0);
    bus(1'b0, 2'b00, 1'b0, 32'h0, 3'd0);
    HWDATA = 32'h0;
    q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    string       s;
    s = "123456789";
    r = SEED_RST;
    for (int i = 0; i < 9; i++) r = crc_step(r, s[i]);
    chk("model_pin_crc_123456789", r, 32'h0376E6E7);

    // reset state
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    chk("rst_hresp", {31'h0, HRESP}, 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    tick();
    HRESETn = 1'b1;

    rd_lit(32'h04, 3'd2, 32'hFFFFFFFF);
    rd_lit(32'h08, 3'd2, 32'hFFFFFFFF);
    rd_lit(32'h10, 3'd2, 32'h00000000);
    run();

    wr_q(32'h00, 3'd2, 32'h31323334);
    wr_seq(32'h00, 32'h35363738);
`ifdef CRC_SUBWORD_EN
    wr_q(32'h00, 3'd0, 32'h00000039);
    rd_lit(32'h04, 3'd2, 32'h0376E6E7);
    rd_lit(32'h10, 3'd2, 32'd9);
    wr_q(32'h02, 3'd1, 32'hABCD0000);
    wr_q(32'h03, 3'd0, 32'h5A000000);
    wr_err(32'h01, 3'd1, 32'h0);
    rd_lit(32'h10, 3'd2, 32'd12);
`else
    wr_err(32'h00, 3'd0, 32'h00000039);
    rd_lit(32'h10, 3'd2, 32'd8);
    wr_err(32'h02, 3'd1, 32'hABCD0000);
    rd_lit(32'h10, 3'd2, 32'd8);
`endif
    rd_lit(32'h01, 3'd0, 32'h0);
    no_dp(1'b1, 2'b00);
    no_dp(1'b1, 2'b01);
    no_dp(1'b0, 2'b10);
    rd_q(32'h40000004);
    rd_lit(32'h00, 3'd2, 32'h0);
    run();

    wr_q(32'h08, 3'd2, 32'h00000000);
    rd_lit(32'h08, 3'd2, 32'h00000000);
    rd_q(32'h04);
    wr_q(32'h0C, 3'd2, 32'h00000001);
    wr_seq(32'h00, 32'h00000000);
    rd_lit(32'h04, 3'd2, 32'h00000000);
    rd_lit(32'h10, 3'd2, 32'd4);
    run();

    wr_err(32'h04, 3'd2, 32'h12345678);
    rd_err(32'h14, 3'd2);
    rd_lit(32'h04, 3'd2, 32'h00000000);
    rd_err(32'h08, 3'd3);
    rd_err(32'h0A, 3'd2);
    rd_err(32'h08, 3'd1);
    wr_err(32'h10, 3'd2, 32'h5);
    wr_err(32'h1C, 3'd2, 32'h1);
    wr_q(32'h0C, 3'd2, 32'h00000000);
    wr_q(32'h08, 3'd2, 32'hA5A5A5A5);
    rd_lit(32'h10, 3'd2, 32'd4);
    rd_lit(32'h04, 3'd2, 32'h00000000);
    run();

    // an address phase forced onto the bus during ERROR cycle 1 must be dropped
    bus(1'b1, 2'b10, 1'b1, 32'h04, 3'd2);
    tick();
    hready_ovr = 1'b1;
    bus(1'b1, 2'b10, 1'b1, 32'h00, 3'd2);
    tick();
    hready_ovr = 1'b0;
    bus(1'b0, 2'b00, 1'b0, 32'h0, 3'd0);
    HWDATA = 32'h11223344;
    tick();
    HWDATA = 32'h0;
    rd_lit(32'h10, 3'd2, 32'd4);
    rd_lit(32'h04, 3'd2, 32'h00000000);
    run();

    for (int i = 0; i < 16384; i++) wr_q(32'h00, 3'd2, 32'(i));
    rd_lit(32'h10, 3'd2, 32'h0000FFFF);
    wr_q(32'h00, 3'd2, 32'h0);
    rd_lit(32'h10, 3'd2, 32'h0000FFFF);
    run();

    // reset in the data phase of a DATA write
    bus(1'b1, 2'b10, 1'b1, 32'h00, 3'd2);
    tick();
    bus(1'b0, 2'b00, 1'b0, 32'h0, 3'd0);
    HWDATA = 32'hCAFEF00D;
    #1 HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    HWDATA = 32'h0;
    rd_lit(32'h04, 3'd2, 32'hFFFFFFFF);
    rd_lit(32'h10, 3'd2, 32'h0);
    wr_q(32'h08, 3'd2, 32'h0BADBEEF);
    run();

    // reset in ERROR cycle 1
    bus(1'b1, 2'b10, 1'b1, 32'h10, 3'd2);
    tick();
    bus(1'b0, 2'b00, 1'b0, 32'h0, 3'd0);
    #1 HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    rd_lit(32'h08, 3'd2, 32'hFFFFFFFF);
    wr_q(32'h00, 3'd2, 32'h31323334);
    rd_lit(32'h10, 3'd2, 32'd4);
    run();

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_crc_slave.md
AHB_CRC_SLAVE -- requirements
Module: ahb_crc_slave

Interface
REQ-001 Parameter POLY, default 32'h04C11DB7, CRC-32 generator polynomial (MSB-first, no reflection, no final XOR).
REQ-002 Parameter SEED_RST, default 32'hFFFFFFFF, reset value of SEED and CRC.
REQ-003 HCLK  in  1  single clock; all state changes on rising edge.
REQ-004 HRESETn  in  1  reset; asynchronous assert, active-low.
REQ-005 HSEL  in  1  slave select.
REQ-006 HADDR  in  32  byte address; only [4:0] decoded.
REQ-007 HTRANS  in  2  transfer type (IDLE, BUSY, NONSEQ, SEQ).
REQ-008 HWRITE  in  1  1 = write.
REQ-009 HSIZE  in  3  0 = byte, 1 = halfword, 2 = word; values above 2 are illegal.
REQ-010 HWDATA  in  32  write data, valid in the data phase.
REQ-011 HREADY  in  1  bus ready; qualifies the address phase.
REQ-012 HREADYOUT  out  1  slave ready.
REQ-013 HRESP  out  1  0 = OKAY, 1 = ERROR.
REQ-014 HRDATA  out  32  read data, valid in the data phase.

Function
REQ-015 Address phase SHALL be accepted only when HSEL=1, HREADY=1 and HTRANS[1]=1; the block registers address, direction and size for the data phase.
- IDLE, BUSY or unselected transfers: zero-wait OKAY, no side effects.
REQ-016 Register map:
- 0x00 DATA: write-only; reads return 0.
- 0x04 CRC: read-only; current CRC.
- 0x08 SEED: read/write.
- 0x0C CTRL: write bit0=1 copies SEED into CRC and clears COUNT; reads return 0.
- 0x10 COUNT: read-only; 16-bit byte count, saturates at 16'hFFFF, zero-extended.
REQ-017 Legal accesses SHALL complete with zero wait states: HREADYOUT=1, HRESP=0 in the data phase.
REQ-018 Write effects SHALL occur at the clock edge that ends the data phase. Reads SHALL return values as of the start of the data phase.
- A CRC read directly after a DATA write reflects that write.
REQ-019 A word DATA write SHALL update CRC over 4 bytes, processed in the order HWDATA[31:24], [23:16], [15:8], [7:0], all in one cycle. COUNT increases by 4.
REQ-020 The following SHALL receive a two-cycle ERROR response:
- unmapped address (0x14-0x1F);
- write to CRC or COUNT;
- HSIZE > 2;
- misaligned access (word with HADDR[1:0]!=0, or halfword with HADDR[0]=1);
- non-word access to any register other than DATA.
REQ-021 ERROR response: cycle 1 HREADYOUT=0, HRESP=1; cycle 2 HREADYOUT=1, HRESP=1. The errored transfer SHALL have no side effects, and any address phase presented during cycle 1 SHALL be ignored.
REQ-022 Back-to-back transfers (NONSEQ/SEQ every cycle) SHALL each be processed. A CTRL init followed immediately by a DATA write SHALL compute from the new SEED.
REQ-023 A write to SEED SHALL NOT change CRC until a CTRL init is written.

Reset
REQ-024 On HRESETn=0 the block SHALL set:
- CRC=SEED_RST, SEED=SEED_RST, COUNT=0;
- HREADYOUT=1, HRESP=0, HRDATA=0;
- data-phase state cleared.
REQ-025 Reset asserted mid-transfer or mid-ERROR SHALL abort the transfer with no partial register update. The first address phase after release SHALL be accepted normally.

Configuration
REQ-026 Macro CRC_SUBWORD_EN controls sub-word DATA writes.
- Defined: byte DATA writes process the lane selected by HADDR[1:0] (little-endian; HADDR[1:0]=0 selects HWDATA[7:0]), COUNT +1. Halfword DATA writes process the selected halfword, upper byte first, COUNT +2.
- Undefined: any non-word DATA write receives the ERROR response of REQ-021 and has no side effects.

Verification
REQ-027 Reset, then read 0x04, 0x08, 0x10 -> 0xFFFFFFFF, 0xFFFFFFFF, 0x00000000, all OKAY with zero wait states.
REQ-028 Word DATA writes 0x31323334 then 0x35363738, then byte write 0x39 at 0x00 (CRC_SUBWORD_EN defined) -> CRC reads 0x0376E6E7 and COUNT reads 9.
REQ-029 Write SEED=0x00000000, write CTRL=1, then back-to-back word DATA write 0x00000000 -> CRC reads 0x00000000 and COUNT reads 4.
REQ-030 Word write to 0x04, then a read of 0x14 -> each gets the ERROR response (HREADYOUT 0 then 1, HRESP 1 for both cycles), and CRC is unchanged.
REQ-031 With CRC_SUBWORD_EN undefined, byte write to 0x00 -> ERROR response and COUNT unchanged.
REQ-032 Assert HRESETn during the data phase of a DATA write -> CRC=0xFFFFFFFF and COUNT=0 after release.
